// File: rtl/mdu_issue_slot_sched.sv
// MDU issue slot: per-unit occupancy timelines plus a shared HI/LO writeback timeline
// gate acceptance of the issue-queue head and register the bundle toward PRF read.
module mdu_issue_slot_sched #(
  parameter int TL_W    = 32,
  parameter int UOP_W   = 64,
  parameter int PRF_AW  = 6,
  parameter int MUL_OCC = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_OCC = 16,
  parameter int DIV_LAT = 17,
  parameter int OTH_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pause,
  input  logic              prim_pause,
  input  logic              issue_valid,
  input  logic [1:0]        issue_class,
  input  logic [UOP_W-1:0]  issue_hi,
  input  logic [UOP_W-1:0]  issue_lo,
  input  logic [PRF_AW-1:0] op0_paddr,
  input  logic [PRF_AW-1:0] op1_paddr,
  output logic              issue_accept,
  output logic              rf_valid,
  output logic [UOP_W-1:0]  rf_hi,
  output logic [UOP_W-1:0]  rf_lo,
  output logic [PRF_AW-1:0] prf_rs0,
  output logic [PRF_AW-1:0] prf_rs1,
  output logic              mul_busy,
  output logic              div_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (MUL_OCC < 1 || MUL_OCC > TL_W || DIV_OCC < 1 || DIV_OCC > TL_W ||
      MUL_LAT < 1 || MUL_LAT > TL_W - 1 || DIV_LAT < 1 || DIV_LAT > TL_W - 1 ||
      OTH_LAT < 1 || OTH_LAT > TL_W - 1) begin : gBadParams
    $error("mdu_issue_slot_sched: occupancy/latency parameter out of range");
  end

  localparam logic [TL_W-1:0] ONE      = TL_W'(1);
  localparam logic [TL_W-1:0] MUL_MASK = (ONE << MUL_OCC) - ONE;
  localparam logic [TL_W-1:0] DIV_MASK = (ONE << DIV_OCC) - ONE;
  // Check bit lat is tested before the shift; set bit lat-1 lands after the shift.
  localparam logic [TL_W-1:0] MUL_CHK  = ONE << MUL_LAT;
  localparam logic [TL_W-1:0] DIV_CHK  = ONE << DIV_LAT;
  localparam logic [TL_W-1:0] OTH_CHK  = ONE << OTH_LAT;
  localparam logic [TL_W-1:0] MUL_SET  = ONE << (MUL_LAT - 1);
  localparam logic [TL_W-1:0] DIV_SET  = ONE << (DIV_LAT - 1);
  localparam logic [TL_W-1:0] OTH_SET  = ONE << (OTH_LAT - 1);

  logic [TL_W-1:0] mulTl, divTl, wbTl;
  logic [TL_W-1:0] wbChk, wbSet;
  logic            hold, unitFree, isMul, isDiv;

  always_comb begin
    hold     = pause | prim_pause;
    wbChk    = '0;
    wbSet    = '0;
    unitFree = 1'b0;
    isMul    = 1'b0;
    isDiv    = 1'b0;
    case (issue_class)
      2'b00: begin
        wbChk    = OTH_CHK;
        wbSet    = OTH_SET;
        unitFree = 1'b1;
      end
      2'b01: begin
        wbChk    = MUL_CHK;
        wbSet    = MUL_SET;
        unitFree = ~mulTl[0];
        isMul    = 1'b1;
      end
      2'b10: begin
        wbChk    = DIV_CHK;
        wbSet    = DIV_SET;
        unitFree = ~divTl[0];
        isDiv    = 1'b1;
      end
      default: unitFree = 1'b0;
    endcase
    issue_accept = issue_valid & ~rst & ~hold & ~flush & unitFree & ((wbTl & wbChk) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mulTl     <= '0;
      divTl     <= '0;
      wbTl      <= '0;
      rf_valid  <= 1'b0;
      rf_hi     <= '0;
      rf_lo     <= '0;
      prf_rs0   <= '0;
      prf_rs1   <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      mulTl    <= '0;
      divTl    <= '0;
      wbTl     <= '0;
      rf_valid <= 1'b0;
      rf_hi    <= '0;
      rf_lo    <= '0;
      prf_rs0  <= '0;
      prf_rs1  <= '0;
    end else if (!hold) begin
      mulTl    <= (mulTl >> 1) | ((issue_accept & isMul) ? MUL_MASK : '0);
      divTl    <= (divTl >> 1) | ((issue_accept & isDiv) ? DIV_MASK : '0);
      wbTl     <= (wbTl >> 1) | (issue_accept ? wbSet : '0);
      rf_valid <= issue_accept;
      if (issue_accept) begin
        rf_hi   <= issue_hi;
        rf_lo   <= issue_lo;
        prf_rs0 <= op0_paddr;
        prf_rs1 <= op1_paddr;
      end
      if (issue_valid && !issue_accept && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign mul_busy = mulTl[0];
  assign div_busy = divTl[0];

endmodule

// File: tb/tb_mdu_issue_slot_sched.sv
// Directed bench for mdu_issue_slot_sched: reset, mul/div occupancy, writeback
// conflicts, pause freeze, flush and stall counter saturation.
module tb_mdu_issue_slot_sched;

  logic        clk = 1'b0;
  logic        rst, flush, pause, prim_pause, issue_valid;
  logic [1:0]  issue_class;
  logic [63:0] issue_hi, issue_lo;
  logic [5:0]  op0_paddr, op1_paddr;
  logic        issue_accept, rf_valid, mul_busy, div_busy;
  logic [63:0] rf_hi, rf_lo;
  logic [5:0]  prf_rs0, prf_rs1;
  logic [15:0] stall_cnt;

  int checkCount = 0;
  int passCount  = 0;
  int accCount;

  localparam logic [1:0] OTH = 2'b00, MUL = 2'b01, DIV = 2'b10, ILL = 2'b11;

  mdu_issue_slot_sched dut (
    .clk(clk), .rst(rst), .flush(flush), .pause(pause), .prim_pause(prim_pause),
    .issue_valid(issue_valid), .issue_class(issue_class),
    .issue_hi(issue_hi), .issue_lo(issue_lo),
    .op0_paddr(op0_paddr), .op1_paddr(op1_paddr),
    .issue_accept(issue_accept), .rf_valid(rf_valid), .rf_hi(rf_hi), .rf_lo(rf_lo),
    .prf_rs0(prf_rs0), .prf_rs1(prf_rs1),
    .mul_busy(mul_busy), .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Drive one head and let the combinational accept settle before sampling.
  task automatic applyStimulus(input logic valid, input logic [1:0] cls,
                               input logic [63:0] hi, input logic [63:0] lo,
                               input logic [5:0] p0, input logic [5:0] p1);
    issue_valid = valid;
    issue_class = cls;
    issue_hi    = hi;
    issue_lo    = lo;
    op0_paddr   = p0;
    op1_paddr   = p1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, OTH, '0, '0, '0, '0);
  endtask

  task automatic doReset();
    rst = 1'b1; flush = 1'b0; pause = 1'b0; prim_pause = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pause = 1'b0; prim_pause = 1'b0;

    // Reset with a valid head present
    applyStimulus(1'b1, MUL, 64'h11, 64'h22, 6'd3, 6'd4);
    checkOutput("rst_accept_a", issue_accept, 1'b0);
    tick();
    checkOutput("rst_accept_b", issue_accept, 1'b0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    checkOutput("rst_rf_valid", rf_valid, 1'b0);
    checkOutput("rst_rf_hi", rf_hi, 64'h0);
    checkOutput("rst_rf_lo", rf_lo, 64'h0);
    checkOutput("rst_rs0", prf_rs0, 6'd0);
    checkOutput("rst_rs1", prf_rs1, 6'd0);
    checkOutput("rst_mul_busy", mul_busy, 1'b0);
    checkOutput("rst_div_busy", div_busy, 1'b0);
    checkOutput("rst_stall", stall_cnt, 16'd0);

    // Back-to-back muls
    applyStimulus(1'b1, MUL, 64'hA0A0, 64'hB0B0, 6'd1, 6'd2);
    checkOutput("b2b_acc0", issue_accept, 1'b1);
    tick();
    checkOutput("b2b_valid1", rf_valid, 1'b1);
    checkOutput("b2b_hi1", rf_hi, 64'hA0A0);
    checkOutput("b2b_lo1", rf_lo, 64'hB0B0);
    checkOutput("b2b_rs0_1", prf_rs0, 6'd1);
    checkOutput("b2b_rs1_1", prf_rs1, 6'd2);
    checkOutput("b2b_busy1", mul_busy, 1'b1);
    applyStimulus(1'b1, MUL, 64'hC0C0, 64'hD0D0, 6'd5, 6'd6);
    checkOutput("b2b_acc1", issue_accept, 1'b0);
    tick();
    checkOutput("b2b_valid2", rf_valid, 1'b0);
    checkOutput("b2b_hi2_hold", rf_hi, 64'hA0A0);
    checkOutput("b2b_busy2", mul_busy, 1'b0);
    checkOutput("b2b_stall2", stall_cnt, 16'd1);
    checkOutput("b2b_acc2", issue_accept, 1'b1);
    tick();
    idle();
    checkOutput("b2b_valid3", rf_valid, 1'b1);
    checkOutput("b2b_hi3", rf_hi, 64'hC0C0);
    checkOutput("b2b_rs0_3", prf_rs0, 6'd5);
    checkOutput("b2b_stall3", stall_cnt, 16'd1);

    // Div then mul: writeback slot 17 conflicts only with a mul issued at cycle 14
    doReset();
    applyStimulus(1'b1, DIV, 64'h1234, 64'h5678, 6'd7, 6'd8);
    checkOutput("dm_acc0", issue_accept, 1'b1);
    tick();
    for (int cyc = 1; cyc <= 17; cyc++) begin
      checkOutput($sformatf("dm_div_busy%0d", cyc), div_busy, (cyc <= 16) ? 1'b1 : 1'b0);
      if (cyc <= 13) begin
        applyStimulus(1'b1, MUL, 64'h99, 64'h98, 6'd9, 6'd10);
        checkOutput($sformatf("dm_mul_probe%0d", cyc), issue_accept, 1'b1);
        idle();
      end else if (cyc == 14) begin
        applyStimulus(1'b1, MUL, 64'h99, 64'h98, 6'd9, 6'd10);
        checkOutput("dm_mul_rej14", issue_accept, 1'b0);
      end else if (cyc == 15) begin
        checkOutput("dm_stall15", stall_cnt, 16'd1);
        checkOutput("dm_mul_acc15", issue_accept, 1'b1);
      end else if (cyc == 16) begin
        idle();
        checkOutput("dm_rf_valid16", rf_valid, 1'b1);
        checkOutput("dm_rf_hi16", rf_hi, 64'h99);
        applyStimulus(1'b1, OTH, 64'h77, 64'h76, 6'd11, 6'd12);
        checkOutput("dm_oth_rej16", issue_accept, 1'b0);
        idle();
      end
      tick();
    end

    // Pause freezes timelines and rf_* outputs
    doReset();
    applyStimulus(1'b1, DIV, 64'hD1, 64'hD2, 6'd13, 6'd14);
    tick();
    idle();
    checkOutput("pz_hi1", rf_hi, 64'hD1);
    tick();
    applyStimulus(1'b1, OTH, 64'hE1, 64'hE2, 6'd15, 6'd16);
    checkOutput("pz_oth_acc2", issue_accept, 1'b1);
    tick();
    applyStimulus(1'b1, OTH, 64'hF1, 64'hF2, 6'd17, 6'd18);
    pause = 1'b1;
    #1;
    checkOutput("pz_acc3", issue_accept, 1'b0);
    for (int cyc = 4; cyc <= 6; cyc++) begin
      tick();
      checkOutput($sformatf("pz_valid%0d", cyc), rf_valid, 1'b1);
      checkOutput($sformatf("pz_hi%0d", cyc), rf_hi, 64'hE1);
      checkOutput($sformatf("pz_rs1_%0d", cyc), prf_rs1, 6'd16);
      checkOutput($sformatf("pz_stall%0d", cyc), stall_cnt, 16'd0);
      if (cyc == 5) prim_pause = 1'b1;
      if (cyc == 5) pause = 1'b0;
    end
    prim_pause = 1'b0;
    idle();
    for (int cyc = 6; cyc < 19; cyc++) tick();
    checkOutput("pz_div_busy19", div_busy, 1'b1);
    tick();
    checkOutput("pz_div_busy20", div_busy, 1'b0);

    // Flush (with pause also asserted) clears state but keeps stall_cnt
    doReset();
    applyStimulus(1'b1, DIV, 64'hAB, 64'hCD, 6'd19, 6'd20);
    tick();
    applyStimulus(1'b1, DIV, 64'hEE, 64'hEF, 6'd21, 6'd22);
    tick();
    idle();
    checkOutput("fl_stall2", stall_cnt, 16'd1);
    tick(); tick(); tick();
    checkOutput("fl_div_busy5", div_busy, 1'b1);
    flush = 1'b1;
    pause = 1'b1;
    applyStimulus(1'b1, MUL, 64'h55, 64'h56, 6'd23, 6'd24);
    checkOutput("fl_acc5", issue_accept, 1'b0);
    tick();
    flush = 1'b0;
    pause = 1'b0;
    idle();
    checkOutput("fl_div_busy6", div_busy, 1'b0);
    checkOutput("fl_rf_valid6", rf_valid, 1'b0);
    checkOutput("fl_rf_hi6", rf_hi, 64'h0);
    checkOutput("fl_stall6", stall_cnt, 16'd1);
    applyStimulus(1'b1, DIV, 64'h66, 64'h67, 6'd25, 6'd26);
    checkOutput("fl_div_acc6", issue_accept, 1'b1);
    tick();
    idle();
    checkOutput("fl_div_busy7", div_busy, 1'b1);
    checkOutput("fl_hi7", rf_hi, 64'h66);

    // Illegal class never accepted; stall counter saturates
    doReset();
    accCount = 0;
    applyStimulus(1'b1, ILL, 64'h1, 64'h2, 6'd1, 6'd2);
    for (int cyc = 0; cyc < 70000; cyc++) begin
      if (issue_accept) accCount++;
      if (cyc == 65534) checkOutput("ill_stall_fffe", stall_cnt, 16'hFFFE);
      tick();
    end
    checkOutput("ill_accepts", accCount, 0);
    checkOutput("ill_stall_sat", stall_cnt, 16'hFFFF);
    checkOutput("ill_rf_valid", rf_valid, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
